alu_seq16: RTL and testbench

- Multi-cycle controller that runs 16-bit add and 16-bit multi-position shifts on the existing 8-bit combinational ALU.
- Splits each operation into byte passes and chains the carry through the ALU's sc_i/sc_o.
- Sits between the decode/control path and the ALU, and owns the ALU's command and operand inputs while busy.
- Uses a start/busy/done handshake and exports a 16-bit result plus carry and zero flags.

---
 rtl/alu_seq16_if.sv | 34 +++
 rtl/alu_seq16.sv | 145 ++++++++++++++
 tb/tb_alu_seq16.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq16_if.sv
// Handshake and ALU-drive bundle for the 16-bit sequencer.
// The master side is decode/control plus the 8-bit ALU.
interface alu_seq16_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  cnt;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic [4:0]  alu_cmd;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_sc_i;
  logic [7:0]  alu_rslt;
  logic        alu_sc_o;

  modport master (
    output start, op, a, b, cnt,
    output alu_rslt, alu_sc_o,
    input  busy, done, result, carry, zero,
    input  alu_cmd, alu_a, alu_b, alu_sc_i
  );

  modport slave (
    input  start, op, a, b, cnt,
    input  alu_rslt, alu_sc_o,
    output busy, done, result, carry, zero,
    output alu_cmd, alu_a, alu_b, alu_sc_i
  );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit add/shift sequencer built on an 8-bit ALU.
// Each op runs as byte passes with the carry chained via sc_i/sc_o.
module alu_seq16 #(
  parameter logic [4:0] CMD_ADD = 5'd0,
  parameter logic [4:0] CMD_LSL = 5'd2,
  parameter logic [4:0] CMD_ASR = 5'd3,
  parameter logic [4:0] CMD_LSR = 5'd4
) (
  input logic        clk,
  input logic        reset,
  alu_seq16_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_P1   = 2'd1;
  localparam logic [1:0] S_P2   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_LSL = 2'd1;
  localparam logic [1:0] OP_LSR = 2'd2;
  localparam logic [1:0] OP_ASR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] w_q, w_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  r_q, r_d;
  logic        c_q, c_d;
  logic [15:0] res_q, res_d;
  logic        cy_q, cy_d;

  logic        busy;
  logic        hi_pass;
  logic [15:0] w_pass;

  assign busy = (state_q == S_P1) || (state_q == S_P2);

  // Right shifts start from the high byte so the carry flows downward
  always_comb begin
    hi_pass = 1'b0;
    unique case (state_q)
      S_P1:    hi_pass = (op_q == OP_LSR) || (op_q == OP_ASR);
      S_P2:    hi_pass = (op_q == OP_ADD) || (op_q == OP_LSL);
      default: hi_pass = 1'b0;
    endcase
  end

  always_comb begin
    bus.alu_cmd  = '0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_sc_i = 1'b0;
    if (busy) begin
      bus.alu_a    = hi_pass ? w_q[15:8] : w_q[7:0];
      bus.alu_sc_i = (state_q == S_P2) && c_q;
      unique case (op_q)
        OP_ADD: begin
          bus.alu_cmd = CMD_ADD;
          bus.alu_b   = hi_pass ? b_q[15:8] : b_q[7:0];
        end
        OP_LSL:  bus.alu_cmd = CMD_LSL;
        OP_LSR:  bus.alu_cmd = CMD_LSR;
        default: bus.alu_cmd = (state_q == S_P1) ? CMD_ASR : CMD_LSR;
      endcase
    end
  end

  assign w_pass = hi_pass ? {bus.alu_rslt, w_q[7:0]}
                          : {w_q[15:8], bus.alu_rslt};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    w_d     = w_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    res_d   = res_q;
    cy_d    = cy_q;
    unique case (state_q)
      S_P1: begin
        w_d     = w_pass;
        c_d     = bus.alu_sc_o;
        state_d = S_P2;
      end
      S_P2: begin
        w_d = w_pass;
        c_d = bus.alu_sc_o;
        r_d = r_q - 4'd1;
        if ((op_q == OP_ADD) || (r_q == 4'd1)) begin
          state_d = S_DONE;
          res_d   = w_pass;
          cy_d    = bus.alu_sc_o;
        end else begin
          state_d = S_P1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start) begin
          op_d = bus.op;
          w_d  = bus.a;
          b_d  = bus.b;
          r_d  = bus.cnt;
          c_d  = 1'b0;
          if ((bus.op != OP_ADD) && (bus.cnt == 4'd0)) begin
            state_d = S_DONE;
            res_d   = bus.a;
            cy_d    = 1'b0;
          end else begin
            state_d = S_P1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      w_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      w_q     <= w_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;
  assign bus.carry  = cy_q;
  assign bus.zero   = (res_q == 16'h0000);
endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: 8-bit ALU model, word-level reference model,
// per-cycle compare, directed literal cases and random traffic.
module tb_alu_seq16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_seq16_if bus();

  alu_seq16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // 8-bit combinational ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_sc_i};
    bus.alu_rslt = 8'h00;
    bus.alu_sc_o = 1'b0;
    case (bus.alu_cmd)
      5'd0: begin
        bus.alu_rslt = alu_sum[7:0];
        bus.alu_sc_o = alu_sum[8];
      end
      5'd2: begin
        bus.alu_rslt = {bus.alu_a[6:0], bus.alu_sc_i};
        bus.alu_sc_o = bus.alu_a[7];
      end
      5'd3: begin
        bus.alu_rslt = {bus.alu_a[7], bus.alu_a[7:1]};
        bus.alu_sc_o = bus.alu_a[0];
      end
      5'd4: begin
        bus.alu_rslt = {bus.alu_sc_i, bus.alu_a[7:1]};
        bus.alu_sc_o = bus.alu_a[0];
      end
      default: ;
    endcase
  end

  // Word-level reference: returns {carry, result}
  function automatic logic [16:0] ref_op(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [3:0] cnt);
    int k;
    logic [31:0] t;
    logic signed [15:0] s;
    k = int'(cnt);
    if (op == 2'd0) return {1'b0, a} + {1'b0, b};
    if (k == 0) return {1'b0, a};
    case (op)
      2'd1: begin
        t = {16'h0000, a} << k;
        return {t[16], t[15:0]};
      end
      2'd2: return {a[k-1], a >> k};
      default: begin
        s = $signed(a) >>> k;
        return {a[k-1], s};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [3:0] cnt);
    if (op == 2'd0) return 3;
    if (cnt == 4'd0) return 1;
    return 2 * int'(cnt) + 1;
  endfunction

  logic [16:0] nxt;
  int          nlat;
  always_comb begin
    nxt  = ref_op(bus.op, bus.a, bus.b, bus.cnt);
    nlat = lat_of(bus.op, bus.cnt);
  end

  int          m_left;
  logic        m_done;
  logic [15:0] m_pend_r, m_vis_r;
  logic        m_pend_c, m_vis_c;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_vis_r <= 16'h0000;
      m_vis_c <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_vis_r <= m_pend_r;
        m_vis_c <= m_pend_c;
      end
    end else if (bus.start) begin
      m_left   <= nlat - 1;
      m_done   <= (nlat == 1);
      m_pend_r <= nxt[15:0];
      m_pend_c <= nxt[16];
      if (nlat == 1) begin
        m_vis_r <= nxt[15:0];
        m_vis_c <= nxt[16];
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(bus.busy), 32'(m_left != 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("result", 32'(bus.result), 32'(m_vis_r));
      chk("carry", 32'(bus.carry), 32'(m_vis_c));
      chk("zero", 32'(bus.zero), 32'(m_vis_r == 16'h0000));
      if (m_left == 0)
        chk("alu_idle",
            32'({bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_sc_i}), 32'd0);
    end
  end

  task automatic launch(input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] cnt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.cnt   = cnt;
  endtask

  // Waits for done, scrambling inputs; optional stray start at edge spur
  task automatic finish(input logic [15:0] er, input logic ec,
                        input int elat, input bit lit, input int spur,
                        input string nm);
    int n;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (!bus.done && n < 40) begin
      bus.start = (n == spur);
      bus.op    = 2'($urandom);
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      bus.cnt   = 4'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else if (lit) begin
      chk({nm, "_lat"}, 32'(n), 32'(elat));
      chk({nm, "_res"}, 32'(bus.result), 32'(er));
      chk({nm, "_cy"}, 32'(bus.carry), 32'(ec));
      chk({nm, "_zero"}, 32'(bus.zero), 32'(er == 16'h0000));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    bus.cnt   = 4'd0;
    #1 reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_zero", 32'(bus.zero), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    launch(2'd0, 16'h12FF, 16'h0001, 4'd0);
    finish(16'h1300, 1'b0, 3, 1'b1, 0, "add_c8");
    @(negedge clk);
    launch(2'd0, 16'hFFFF, 16'h0001, 4'd0);
    finish(16'h0000, 1'b1, 3, 1'b1, 0, "add_wrap");
    @(negedge clk);
    launch(2'd1, 16'h8001, 16'h0000, 4'd1);
    finish(16'h0002, 1'b1, 3, 1'b1, 0, "lsl1");
    launch(2'd1, 16'h0F0F, 16'h0000, 4'd4);
    finish(16'hF0F0, 1'b0, 9, 1'b1, 0, "lsl4");
    launch(2'd2, 16'h8001, 16'h0000, 4'd1);
    finish(16'h4000, 1'b1, 3, 1'b1, 0, "lsr1");
    launch(2'd3, 16'h8000, 16'h0000, 4'd3);
    finish(16'hF000, 1'b0, 7, 1'b1, 0, "asr3");
    launch(2'd3, 16'h7FFF, 16'h0000, 4'd15);
    finish(16'h0000, 1'b1, 31, 1'b1, 0, "asr15");
    @(negedge clk);
    launch(2'd1, 16'h1234, 16'h0000, 4'd0);
    finish(16'h1234, 1'b0, 1, 1'b1, 0, "lsl0");
    launch(2'd0, 16'h0001, 16'h0002, 4'd0);
    finish(16'h0003, 1'b0, 3, 1'b1, 0, "b2b_add");

    launch(2'd1, 16'h81C3, 16'h0000, 4'd8);
    finish(16'hC300, 1'b1, 17, 1'b1, 2, "lsl8_spur");

    @(negedge clk);
    launch(2'd1, 16'h5A5A, 16'h0000, 4'd8);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_result", 32'(bus.result), 32'h0);
    chk("mid_rst_carry", 32'(bus.carry), 32'h0);
    chk("mid_rst_zero", 32'(bus.zero), 32'h1);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", 32'(bus.done), 32'h0);
    launch(2'd0, 16'h00FF, 16'h0F01, 4'd0);
    finish(16'h1000, 1'b0, 3, 1'b1, 0, "add_after_rst");

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      launch(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom));
      finish(16'h0, 1'b0, 0, 1'b0, $urandom_range(0, 4), "rand");
    end
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
